sbox_word_sequencer: RTL and testbench
======================================

# sbox_word_sequencer

Controller that pushes one 32-bit word through a single shared byte-wide S-box, one byte at a time, then returns the reassembled 32-bit result. It optionally applies RotWord before substitution and an Rcon XOR afterwards, so it serves as the SubWord stage of AES key expansion. It sits between the key-schedule logic (upstream) and one S-box instance (downstream). The S-box is instantiated by the parent and wired to the `sb_*` ports.

## Interface
Parameters:
- `NB`, default 4: bytes per word. The Rcon and RotWord rules below hold only for `NB = 4`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low. Release is synchronised externally.
- `w_valid`  in  1: upstream word valid.
- `w_ready`  out  1: sequencer can accept a word.
- `w_data`  in  32: input word. Byte lane 0 is `[31:24]`.
- `w_rot`  in  1: apply RotWord before substitution.
- `w_rcon`  in  8: XORed into result lane 0 after substitution. Use 0 for none.
- `r_valid`  out  1: result word valid.
- `r_ready`  in  1: downstream accepts the result.
- `r_data`  out  32: result word.
- `sb_idata`  out  8: byte sent to the S-box.
- `sb_ivalid`  out  1: S-box input valid.
- `sb_iready`  in  1: S-box can accept a byte.
- `sb_odata`  in  8: S-box result byte.
- `sb_ovalid`  in  1: S-box result valid.
- `sb_oready`  out  1: sequencer accepts an S-box result.
- `err`  out  1: sticky protocol error flag. Cleared only by reset.

## Operation
States:
- **IDLE**
  - `w_ready`=1.
  - On `w_valid`: latch the word. If `w_rot`=1, latch the rotated form `{w[23:0], w[31:24]}`; otherwise latch it unchanged. Latch `w_rcon`.
  - Clear the issue count `icnt` and collect count `ccnt`. Go to RUN.
- **RUN**
  - Issue side: `sb_ivalid` = (`icnt` < NB). `sb_idata` = lane `icnt` of the latched word, lane 0 first. `icnt` increments on `sb_ivalid && sb_iready`.
  - Collect side: `sb_oready` = (`ccnt` < NB). On `sb_ovalid && sb_oready`, write `sb_odata` into result lane `ccnt`, then increment `ccnt`.
  - Issue and collect run independently. S-box latency and depth are arbitrary. Results return in issue order.
  - When the collect for lane NB-1 completes: XOR `rcon` into lane 0 in the same register write, then go to DONE.
- **DONE**
  - `r_valid`=1 and `r_data` is held stable.
  - On `r_ready`: return to IDLE.
  - No new word is accepted until the next cycle, so `w_ready` is 0 while in DONE.

Counters `icnt` and `ccnt` are `$clog2(NB+1)` bits wide. They saturate at NB and never wrap.

Boundary conditions:
- `sb_ovalid` outside RUN, or with `ccnt` = NB: the byte is dropped, `err` is set, and state is unchanged. `sb_oready` is 0 in these cases.
- `ccnt` can never exceed `icnt`. If `sb_ovalid` arrives while `ccnt` = `icnt`, it is a protocol error: the byte is still collected and `err` is set.
- `sb_iready` low stalls issue only. Collection continues.
- `r_ready` held low keeps DONE indefinitely. The S-box sees no traffic during this time.
- Reset mid-RUN clears all state immediately. Bytes already in flight in the S-box may return later and set `err`, so the parent must reset both blocks together.

## Timing
- Reset values:
  - State IDLE.
  - `w_ready`=1.
  - `r_valid`=0.
  - `r_data`=0.
  - `sb_ivalid`=0.
  - `sb_idata`=0.
  - `sb_oready`=0.
  - `err`=0.
- All outputs are driven from registers or state decode. There is no combinational path from `w_valid`, `r_ready` or `sb_*` inputs to any output.
- Word accepted at edge T:
  - Lane 0 is offered at T+1.
  - With `sb_iready` held high, lane k is issued at T+1+k.
- With an S-box latency of L cycles (`sb_ovalid` L cycles after issue), the last collect occurs at T+NB+L and `r_valid` rises at T+NB+L+1.
- Back-to-back words: throughput is one word per NB+L+2 cycles. The sequencer never overlaps two words.

## Structure
- Shared package `sbox_pkg` holds:
  - the state enum (`SEQ_IDLE`, `SEQ_RUN`, `SEQ_DONE`);
  - `BYTE_W` = 8;
  - `AES_RCON[0:9]` constants for the key-schedule caller.
- No sub-module. Lane select and lane write are plain indexed logic.
- The S-box stays outside the block, so one S-box can be reused or shared by a higher-level arbiter.

## Test plan
The bench uses an AES S-box model with configurable latency L.

- **Zero word:** `w_data`=0x00000000, rot=0, rcon=0, L=1 → `r_data`=0x63636363; `r_valid` rises 6 cycles after accept.
- **FIPS-197 key step:** `w_data`=0x09CF4F3C, rot=1, rcon=0x01 → issued bytes CF,4F,3C,09 in order; `r_data`=0x8B84EB01.
- **Input stall:** same word as the zero-word case, with `sb_iready` low for 3 cycles after lane 1 → same result, and `r_valid` is 3 cycles later than the unstalled run.
- **Output backpressure:** `r_ready` low for 10 cycles → `r_data` stable, `w_ready`=0 and no S-box traffic throughout; one result transfer when `r_ready` rises.
- **Error case:** inject `sb_ovalid` in IDLE → `err`=1 and held; the next word still computes correctly.
- **Mid-operation reset:** assert `rst_n`=0 mid-RUN → all outputs return to reset values asynchronously; after release, word 0x00000000 gives 0x63636363.

Source files
------------

// File: rtl/sbox_pkg.sv
// Shared definitions for the S-box word sequencer and its key-schedule caller.
package sbox_pkg;

  localparam int BYTE_W = 8;

  // Sequencer control states.
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  // AES key-expansion round constants, lane-0 byte of Rcon[i+1].
  localparam logic [BYTE_W-1:0] AES_RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

endpackage

// File: rtl/sbox_word_sequencer.sv
// Streams one word through a shared byte-wide S-box lane by lane (lane 0 =
// most significant byte), optionally rotating first and XORing an Rcon byte
// into lane 0 afterwards, then presents the reassembled word.
//
// Handshakes: every channel (w_*, r_*, sb_i*, sb_o*) transfers on a rising
// edge where valid and ready are both high. Once raised, this block's valid
// outputs and their data stay stable until the transfer; all outputs come
// from registers or state decode, never combinationally from inputs.
module sbox_word_sequencer
  import sbox_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [NB*BYTE_W-1:0] w_data,
  input  logic                 w_rot,
  input  logic [BYTE_W-1:0]    w_rcon,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [NB*BYTE_W-1:0] r_data,
  output logic [BYTE_W-1:0]    sb_idata,
  output logic                 sb_ivalid,
  input  logic                 sb_iready,
  input  logic [BYTE_W-1:0]    sb_odata,
  input  logic                 sb_ovalid,
  output logic                 sb_oready,
  output logic                 err,
  output seq_state_e           dbg_state_o
);

  localparam int WORD_W = NB * BYTE_W;
  localparam int CW     = $clog2(NB + 1);

  seq_state_e                  state_q, state_d;
  logic [NB-1:0][BYTE_W-1:0]   word_q, word_d;
  logic [NB-1:0][BYTE_W-1:0]   res_q, res_d;
  logic [BYTE_W-1:0]           rcon_q, rcon_d;
  logic [CW-1:0]               icnt_q, icnt_d;
  logic [CW-1:0]               ccnt_q, ccnt_d;
  logic                        err_q, err_d;

  logic                        in_run;
  logic                        issue_ok;
  logic                        collect_ok;
  logic [BYTE_W-1:0]           issue_byte;

  assign in_run     = (state_q == SEQ_RUN);
  // Counters saturate at NB, so these also stop traffic once a word is done.
  assign issue_ok   = in_run && (icnt_q < CW'(NB));
  assign collect_ok = in_run && (ccnt_q < CW'(NB));

  // Select the lane currently being offered to the S-box.
  always_comb begin
    issue_byte = '0;
    for (int k = 0; k < NB; k++) begin
      if (icnt_q == CW'(k)) issue_byte = word_q[NB-1-k];
    end
  end

  // Next-state, counter, lane-write and error-flag logic.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    res_d   = res_q;
    rcon_d  = rcon_q;
    icnt_d  = icnt_q;
    ccnt_d  = ccnt_q;
    err_d   = err_q;

    // A result byte nobody asked for is dropped but remembered as an error.
    if (sb_ovalid && !collect_ok) err_d = 1'b1;

    unique case (state_q)
      SEQ_IDLE: begin
        if (w_valid) begin
          word_d  = w_rot ? {w_data[WORD_W-BYTE_W-1:0], w_data[WORD_W-1 -: BYTE_W]}
                          : w_data;
          rcon_d  = w_rcon;
          icnt_d  = '0;
          ccnt_d  = '0;
          state_d = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        if (issue_ok && sb_iready) icnt_d = icnt_q + CW'(1);
        if (sb_ovalid && collect_ok) begin
          // More results than issues means the S-box broke ordering/count.
          if (ccnt_q == icnt_q) err_d = 1'b1;
          for (int k = 0; k < NB; k++) begin
            if (ccnt_q == CW'(k)) res_d[NB-1-k] = sb_odata;
          end
          ccnt_d = ccnt_q + CW'(1);
          if (ccnt_q == CW'(NB-1)) begin
            res_d[NB-1] = res_d[NB-1] ^ rcon_q;
            state_d     = SEQ_DONE;
          end
        end
      end
      SEQ_DONE: begin
        if (r_ready) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      word_q  <= '0;
      res_q   <= '0;
      rcon_q  <= '0;
      icnt_q  <= '0;
      ccnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      res_q   <= res_d;
      rcon_q  <= rcon_d;
      icnt_q  <= icnt_d;
      ccnt_q  <= ccnt_d;
      err_q   <= err_d;
    end
  end

  assign w_ready     = (state_q == SEQ_IDLE);
  assign r_valid     = (state_q == SEQ_DONE);
  assign r_data      = res_q;
  assign sb_ivalid   = issue_ok;
  assign sb_idata    = issue_ok ? issue_byte : '0;
  assign sb_oready   = collect_ok;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sbox_word_sequencer.sv
// Bench for sbox_word_sequencer: AES S-box responder with configurable
// latency, word-level reference model, directed cases and a random phase.
module tb_sbox_word_sequencer;
  import sbox_pkg::*;

  localparam int NB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   edge_n = 0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  // ---------------- DUT signals ----------------
  logic        w_valid, w_ready, w_rot;
  logic [31:0] w_data;
  logic [7:0]  w_rcon;
  logic        r_valid, r_ready;
  logic [31:0] r_data;
  logic [7:0]  sb_idata;
  logic        sb_ivalid, sb_iready;
  logic [7:0]  sb_odata  = 8'h00;
  logic        sb_ovalid = 1'b0;
  logic        sb_oready, err;
  seq_state_e  dbg_state;

  sbox_word_sequencer #(.NB(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_rot(w_rot), .w_rcon(w_rcon),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .sb_idata(sb_idata), .sb_ivalid(sb_ivalid), .sb_iready(sb_iready),
    .sb_odata(sb_odata), .sb_ovalid(sb_ovalid), .sb_oready(sb_oready),
    .err(err), .dbg_state_o(dbg_state)
  );

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S(a) = affine(a^-1) over GF(2^8), inverse computed as a^254.
  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] prep_word(input logic [31:0] w, input logic rot);
    return rot ? {w[23:0], w[31:24]} : w;
  endfunction

  function automatic logic [31:0] ref_subword(input logic [31:0] w, input logic rot,
                                              input logic [7:0] rc);
    logic [31:0] p = prep_word(w, rot);
    logic [31:0] r;
    r = {sbox_t[p[31:24]], sbox_t[p[23:16]], sbox_t[p[15:8]], sbox_t[p[7:0]]};
    r[31:24] = r[31:24] ^ rc;
    return r;
  endfunction

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  iss_q[$];
  logic [7:0]  pipe_data[$];
  int          pipe_due[$];
  int          lat = 1;
  logic        inject = 1'b0;
  logic        exp_err = 1'b0;
  int          acc_cnt = 0, acc_edge = 0, prev_acc_edge = 0;
  int          n_res = 0, last_lat = 0, iss_cnt = 0;
  logic        rv_seen = 1'b0;
  logic [31:0] last_r = '0;
  logic [7:0]  iss_log [4];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_rdata = '0;
  logic        rnd_mode = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // S-box responder plus the per-cycle compare process. Runs on the falling
  // edge, so it sees exactly the values the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      pipe_data.delete(); pipe_due.delete();
      exp_q.delete(); iss_q.delete();
      exp_err    = 1'b0;
      sb_ovalid  = 1'b0;
      sb_odata   = 8'h00;
      prev_hold  = 1'b0;
    end else begin
      // S-box output for the coming edge: in-order, fixed latency.
      if (inject) begin
        sb_ovalid = 1'b1; sb_odata = 8'hAA;
      end else if (pipe_due.size() > 0 && pipe_due[0] <= edge_n + 1) begin
        sb_ovalid = 1'b1; sb_odata = pipe_data[0];
      end else begin
        sb_ovalid = 1'b0; sb_odata = 8'($urandom);
      end

      check("err_flag", {31'd0, err}, {31'd0, exp_err});

      if (r_valid) begin
        check("w_ready_in_done", {31'd0, w_ready}, 32'd0);
        check("no_sbox_traffic_in_done", {31'd0, sb_ivalid}, 32'd0);
        if (prev_hold) check("r_data_hold", r_data, prev_rdata);
        if (!rv_seen) begin
          rv_seen  = 1'b1;
          last_lat = edge_n + 1 - acc_edge;
        end
      end

      if (sb_ivalid && sb_iready) begin
        if (iss_q.size() == 0) check("unexpected_issue", {24'd0, sb_idata}, 32'hFFFF_FFFF);
        else check("issue_byte", {24'd0, sb_idata}, {24'd0, iss_q.pop_front()});
        if (iss_cnt < 4) iss_log[iss_cnt] = sb_idata;
        iss_cnt++;
        pipe_data.push_back(sbox_t[sb_idata]);
        pipe_due.push_back(edge_n + 1 + lat);
      end

      if (inject) begin
        check("oready_while_idle", {31'd0, sb_oready}, 32'd0);
      end else if (sb_ovalid && sb_oready) begin
        void'(pipe_data.pop_front());
        void'(pipe_due.pop_front());
      end

      if (r_valid && r_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", r_data, 32'hDEAD_BEEF);
        else check("r_data", r_data, exp_q.pop_front());
        last_r = r_data;
        n_res++;
      end

      if (w_valid && w_ready) begin
        logic [31:0] p;
        p = prep_word(w_data, w_rot);
        exp_q.push_back(ref_subword(w_data, w_rot, w_rcon));
        for (int k = 0; k < 4; k++) iss_q.push_back(p[31-8*k -: 8]);
        prev_acc_edge = acc_edge;
        acc_edge      = edge_n + 1;
        acc_cnt++;
        iss_cnt = 0;
        rv_seen = 1'b0;
      end

      prev_hold  = r_valid && !r_ready;
      prev_rdata = r_data;
      if (inject) exp_err = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd_mode) begin
        sb_iready = ($urandom_range(0, 3) != 0);
        r_ready   = ($urandom_range(0, 1) != 0);
      end
    end
  endtask

  task automatic send(input logic [31:0] w, input logic rot, input logic [7:0] rc);
    int a0 = acc_cnt;
    int t  = 0;
    w_data = w; w_rot = rot; w_rcon = rc; w_valid = 1'b1;
    while (acc_cnt == a0 && t < 300) begin wait_cyc(1); t++; end
    if (acc_cnt == a0) check("accept_timeout", 32'(t), 32'd0);
    w_valid = 1'b0;
  endtask

  task automatic wait_result(input int target);
    int t = 0;
    while (n_res < target && t < 300) begin wait_cyc(1); t++; end
    if (n_res < target) check("result_timeout", 32'(n_res), 32'(target));
  endtask

  task automatic run_word(input logic [31:0] w, input logic rot, input logic [7:0] rc);
    int r0 = n_res;
    send(w, rot, rc);
    wait_result(r0 + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_ready"},   {31'd0, w_ready},   32'd1);
    check({tag, "_r_valid"},   {31'd0, r_valid},   32'd0);
    check({tag, "_r_data"},    r_data,             32'd0);
    check({tag, "_sb_ivalid"}, {31'd0, sb_ivalid}, 32'd0);
    check({tag, "_sb_idata"},  {24'd0, sb_idata},  32'd0);
    check({tag, "_sb_oready"}, {31'd0, sb_oready}, 32'd0);
    check({tag, "_err"},       {31'd0, err},       32'd0);
    check({tag, "_state"},     32'(dbg_state),     32'(SEQ_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  fips_iss [4];
    logic [31:0] w;
    int          r0, a0, t, idx;

    for (int i = 0; i < 256; i++) sbox_t[i] = aes_sbox(8'(i));
    fips_iss[0] = 8'hCF; fips_iss[1] = 8'h4F; fips_iss[2] = 8'h3C; fips_iss[3] = 8'h09;

    rst_n = 1'b0; w_valid = 1'b0; w_data = '0; w_rot = 1'b0; w_rcon = '0;
    r_ready = 1'b1; sb_iready = 1'b1;
    #1;
    check_reset_outputs("reset");
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);

    // Zero word, latency 1.
    lat = 1;
    run_word(32'h0000_0000, 1'b0, 8'h00);
    check("zero_word", last_r, 32'h6363_6363);
    check("zero_latency", 32'(last_lat), 32'd6);

    // FIPS-197 key expansion step.
    run_word(32'h09CF_4F3C, 1'b1, 8'h01);
    check("fips_word", last_r, 32'h8B84_EB01);
    for (int k = 0; k < 4; k++) check("fips_issue_order", {24'd0, iss_log[k]}, {24'd0, fips_iss[k]});

    // Input stall: sb_iready low for 3 cycles after lane 1.
    r0 = n_res;
    send(32'h0000_0000, 1'b0, 8'h00);
    t = 0;
    while (iss_cnt < 2 && t < 50) begin wait_cyc(1); t++; end
    check("stall_lane1_issued", 32'(iss_cnt), 32'd2);
    sb_iready = 1'b0;
    wait_cyc(3);
    sb_iready = 1'b1;
    wait_result(r0 + 1);
    check("stall_word", last_r, 32'h6363_6363);
    check("stall_latency", 32'(last_lat), 32'd9);

    // Back-to-back words: accept period NB+L+2.
    r0 = n_res; a0 = acc_cnt; t = 0;
    w_data = 32'h0011_2233; w_rot = 1'b0; w_rcon = 8'h00; w_valid = 1'b1;
    while (acc_cnt < a0 + 2 && t < 100) begin wait_cyc(1); t++; end
    w_valid = 1'b0;
    check("b2b_period", 32'(acc_edge - prev_acc_edge), 32'd7);
    wait_result(r0 + 2);

    // Output backpressure for 10 cycles.
    r_ready = 1'b0;
    r0 = n_res;
    send(32'hA5A5_0F0F, 1'b1, 8'h36);
    t = 0;
    while (!r_valid && t < 50) begin wait_cyc(1); t++; end
    check("bp_r_valid_seen", {31'd0, r_valid}, 32'd1);
    wait_cyc(10);
    check("bp_no_transfer", 32'(n_res), 32'(r0));
    r_ready = 1'b1;
    wait_cyc(1);
    check("bp_one_transfer", 32'(n_res), 32'(r0 + 1));
    wait_cyc(2);
    check("bp_single_transfer", 32'(n_res), 32'(r0 + 1));
    check("bp_result", last_r, ref_subword(32'hA5A5_0F0F, 1'b1, 8'h36));

    // Stray S-box result in IDLE sets the sticky error.
    inject = 1'b1;
    wait_cyc(1);
    inject = 1'b0;
    wait_cyc(2);
    check("err_after_inject", {31'd0, err}, 32'd1);
    run_word(32'h09CF_4F3C, 1'b1, 8'h01);
    check("word_after_err", last_r, 32'h8B84_EB01);
    check("err_sticky", {31'd0, err}, 32'd1);

    // Randomized phase: random words, latency, stalls and backpressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      lat = $urandom_range(1, 4);
      w   = $urandom;
      idx = $urandom_range(0, 10);
      r0  = n_res;
      send(w, ($urandom_range(0, 1) != 0), (idx == 10) ? 8'h00 : AES_RCON[idx]);
      wait_result(r0 + 1);
    end
    rnd_mode = 1'b0;
    r_ready = 1'b1; sb_iready = 1'b1; lat = 1;
    wait_cyc(2);

    // Reset in the middle of RUN.
    send(32'h1234_5678, 1'b0, 8'h00);
    wait_cyc(2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);
    run_word(32'h0000_0000, 1'b0, 8'h00);
    check("post_reset_word", last_r, 32'h6363_6363);
    check("post_reset_err", {31'd0, err}, 32'd0);

    wait_cyc(3);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("iss_q_drained", 32'(iss_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
